// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory (syncram, registered q) between the
//   processor load/store path (port P) and the debug/loader path (port D).
//   Each access runs through fixed GRANT, CAPTURE and DONE cycles, so the
//   latency from request to done is always 3 cycles. Simultaneous requests
//   are resolved round-robin, and P wins the first tie after reset.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   {p,d}_req_i              request, held until the matching done pulse
//   {p,d}_we_i               1 = write, 0 = read
//   {p,d}_addr_i/_wdata_i    word address / write data, stable with req
//   {p,d}_gnt_o              one-cycle pulse: request accepted
//   {p,d}_done_o             one-cycle pulse: access complete
//   {p,d}_rdata_o            read data, held until that port's next read
//   mem_address_o/_data_o    to dmem address/data, held between accesses
//   mem_wren_o               to dmem wren, high only in GRANT for writes
//   mem_q_i                  from dmem q, valid in CAPTURE
//   busy_o                   high whenever the sequencer is not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request; arbitrate and latch the winner
// S_GRANT   | gnt pulse; dmem samples address/data/wren at cycle end
// S_CAPTURE | mem_q valid; a read stores it into the owner's rdata
// S_DONE    | done pulse to the owner; requests are ignored
module dmem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              p_req_i,
   input  logic              p_we_i,
   input  logic [ADDR_W-1:0] p_addr_i,
   input  logic [DATA_W-1:0] p_wdata_i,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              p_gnt_o,
   output logic              d_gnt_o,
   output logic              p_done_o,
   output logic              d_done_o,
   output logic [DATA_W-1:0] p_rdata_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic [ADDR_W-1:0] mem_address_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_wren_o,
   input  logic [DATA_W-1:0] mem_q_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state_q;
   logic              last_q;    // 1 = D won the most recent grant
   logic              owner_q;   // 1 = D owns the access in flight
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              wren_q;
   logic              p_gnt_q, d_gnt_q, p_done_q, d_done_q, busy_q;
   logic [DATA_W-1:0] p_rdata_q, d_rdata_q;
   logic              winner;    // 1 = D

   // A lone requester wins; on a tie the port that did not win last time wins.
   always_comb begin
      winner = d_req_i;
      if (p_req_i && d_req_i) begin
         winner = ~last_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         wren_q    <= 1'b0;
         p_gnt_q   <= 1'b0;
         d_gnt_q   <= 1'b0;
         p_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         busy_q    <= 1'b0;
         p_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         // pulses default low; each is set for exactly one cycle below
         p_gnt_q  <= 1'b0;
         d_gnt_q  <= 1'b0;
         p_done_q <= 1'b0;
         d_done_q <= 1'b0;
         wren_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (p_req_i || d_req_i) begin
                  owner_q <= winner;
                  last_q  <= winner;
                  addr_q  <= winner ? d_addr_i  : p_addr_i;
                  data_q  <= winner ? d_wdata_i : p_wdata_i;
                  we_q    <= winner ? d_we_i    : p_we_i;
                  // wren is registered here so it is high during GRANT only
                  wren_q  <= winner ? d_we_i    : p_we_i;
                  p_gnt_q <= ~winner;
                  d_gnt_q <= winner;
                  busy_q  <= 1'b1;
                  state_q <= S_GRANT;
               end
            end
            S_GRANT: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (!we_q) begin
                  if (owner_q) begin
                     d_rdata_q <= mem_q_i;
                  end else begin
                     p_rdata_q <= mem_q_i;
                  end
               end
               p_done_q <= ~owner_q;
               d_done_q <= owner_q;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign p_gnt_o       = p_gnt_q;
   assign d_gnt_o       = d_gnt_q;
   assign p_done_o      = p_done_q;
   assign d_done_o      = d_done_q;
   assign p_rdata_o     = p_rdata_q;
   assign d_rdata_o     = d_rdata_q;
   assign mem_address_o = addr_q;
   assign mem_data_o    = data_q;
   assign mem_wren_o    = wren_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Drives dmem_arbiter against a behavioural syncram, with a table of
//   single-port accesses, hand sequences for ties, write isolation and reset
//   during an access, and a randomized two-port phase checked cycle by cycle
//   against a transaction-level reference model.
module tb_dmem_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b1;
   logic          p_req_i = 1'b0, p_we_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
   logic [AW-1:0] p_addr_i = '0, d_addr_i = '0;
   logic [DW-1:0] p_wdata_i = '0, d_wdata_i = '0;
   logic          p_gnt_o, d_gnt_o, p_done_o, d_done_o, mem_wren_o, busy_o;
   logic [DW-1:0] p_rdata_o, d_rdata_o, mem_data_o;
   logic [AW-1:0] mem_address_o;
   logic [DW-1:0] mem_q_i = '0;

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .p_req_i(p_req_i), .p_we_i(p_we_i), .p_addr_i(p_addr_i), .p_wdata_i(p_wdata_i),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .p_gnt_o(p_gnt_o), .d_gnt_o(d_gnt_o), .p_done_o(p_done_o), .d_done_o(d_done_o),
      .p_rdata_o(p_rdata_o), .d_rdata_o(d_rdata_o),
      .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_wren_o(mem_wren_o),
      .mem_q_i(mem_q_i), .busy_o(busy_o)
   );

   // Power-up contents of every word the bench never wrote.
   function automatic logic [31:0] init_word(input logic [11:0] a);
      return 32'hA5A5_0000 | {20'd0, a};
   endfunction

   // Behavioural dmem: registered read, write on wren.
   logic [DW-1:0] dmem [0:4095];
   bit            written [0:4095];
   always @(posedge clk_i) begin
      if (mem_wren_o) begin
         dmem[mem_address_o]    <= mem_data_o;
         written[mem_address_o] <= 1'b1;
      end
      mem_q_i <= written[mem_address_o] ? dmem[mem_address_o] : init_word(mem_address_o);
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] ctl6();
      return {p_gnt_o, d_gnt_o, p_done_o, d_done_o, mem_wren_o, busy_o};
   endfunction

   function automatic logic [127:0] all_outs();
      return {ctl6(), mem_address_o, mem_data_o, p_rdata_o, d_rdata_o};
   endfunction

   typedef struct {
      bit          we;
      logic [11:0] addr;
      logic [31:0] wdata;
   } txn_t;

   // What the DUT should currently hold, kept at the level of the rules.
   logic [31:0] shadow [0:4095];
   bit          last_m;          // port that won most recently: 0 = P, 1 = D
   logic [31:0] exp_rd [2];
   logic [11:0] exp_maddr;
   logic [31:0] exp_mdata;

   function automatic void reset_model();
      last_m    = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_maddr = '0;
      exp_mdata = '0;
   endfunction

   task automatic drive(input bit p, input bit req, input txn_t t);
      if (!p) begin
         p_req_i = req; p_we_i = t.we; p_addr_i = t.addr; p_wdata_i = t.wdata;
      end else begin
         d_req_i = req; d_we_i = t.we; d_addr_i = t.addr; d_wdata_i = t.wdata;
      end
   endtask

   // One access on one port with the other idle; arbiter assumed idle.
   task automatic single_access(input bit port, input txn_t t, input logic [31:0] exp_read,
                                input string tag);
      logic [23:0] tr, etr;
      logic [11:0] ma1;
      logic [31:0] md1, rd_own, rd_oth;
      tr = '0; ma1 = '0; md1 = '0; rd_own = '0; rd_oth = '0;
      @(negedge clk_i);
      drive(port, 1'b1, t);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i);
         tr = {tr[17:0], (port ? d_gnt_o : p_gnt_o), (port ? d_done_o : p_done_o),
               (port ? p_gnt_o : d_gnt_o), (port ? p_done_o : d_done_o), mem_wren_o, busy_o};
         if (k == 1) begin ma1 = mem_address_o; md1 = mem_data_o; end
         if (k == 3) begin
            rd_own = port ? d_rdata_o : p_rdata_o;
            rd_oth = port ? p_rdata_o : d_rdata_o;
            drive(port, 1'b0, t);
         end
      end
      // cycle 1 gnt (+wren for a write), cycle 3 done, cycle 4 idle
      etr = {1'b1, 1'b0, 1'b0, 1'b0, t.we, 1'b1, 6'b000001, 6'b010001, 6'b000000};
      last_m    = port;
      exp_maddr = t.addr;
      exp_mdata = t.wdata;
      if (t.we) shadow[t.addr] = t.wdata;
      else      exp_rd[port]   = exp_read;
      check({tag, "_trace"},     tr, etr);
      check({tag, "_memport"},   {ma1, md1}, {t.addr, t.wdata});
      check({tag, "_rdata_own"}, rd_own, exp_rd[port]);
      check({tag, "_rdata_oth"}, rd_oth, exp_rd[!port]);
   endtask

   // ---- two-port engine with transaction-level reference model ----
   txn_t q_p[$], q_d[$];
   txn_t cur [2];
   bit   req_a [2];
   int   cyc, next_free, g_cyc;
   bit   g_port, g_we;
   logic [11:0] g_addr;
   logic [31:0] g_wdata, g_exp;
   int   log_cyc[$];
   bit   log_port[$];

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(1));
      t.addr  = ($urandom_range(3) == 0) ? 12'($urandom_range(4095)) : 12'($urandom_range(15));
      t.wdata = $urandom;
      return t;
   endfunction

   task automatic engine_cycle(input int pct, input string tag);
      bit         edone [2];
      bit         w;
      logic [5:0] ectl;
      for (int p = 0; p < 2; p++) edone[p] = (cyc == g_cyc + 2) && (int'(g_port) == p);
      if (cyc == g_cyc) begin exp_maddr = g_addr; exp_mdata = g_wdata; end
      if (cyc == g_cyc + 2 && !g_we) exp_rd[g_port] = g_exp;
      ectl = {(cyc == g_cyc) && !g_port, (cyc == g_cyc) && g_port, edone[0], edone[1],
              (cyc == g_cyc) && g_we, (cyc >= g_cyc) && (cyc <= g_cyc + 2)};
      check({tag, "_ctl"},   {ctl6(), mem_address_o, mem_data_o}, {ectl, exp_maddr, exp_mdata});
      check({tag, "_rdata"}, {p_rdata_o, d_rdata_o}, {exp_rd[0], exp_rd[1]});
      if (p_gnt_o) begin log_cyc.push_back(cyc); log_port.push_back(1'b0); end
      if (d_gnt_o) begin log_cyc.push_back(cyc); log_port.push_back(1'b1); end
      // requesters: drop after done, then possibly present a new access
      for (int p = 0; p < 2; p++) begin
         if (req_a[p] && edone[p]) req_a[p] = 1'b0;
         if (!req_a[p]) begin
            if (p == 0 && q_p.size() > 0) begin
               cur[p] = q_p.pop_front(); req_a[p] = 1'b1;
            end else if (p == 1 && q_d.size() > 0) begin
               cur[p] = q_d.pop_front(); req_a[p] = 1'b1;
            end else if (pct > 0 && $urandom_range(99) < pct) begin
               cur[p] = rand_txn(); req_a[p] = 1'b1;
            end
         end
         drive(1'(p), req_a[p], cur[p]);
      end
      // a request seen while free is granted next cycle; free again 4 cycles on
      if (cyc >= next_free && (req_a[0] || req_a[1])) begin
         w         = (req_a[0] && req_a[1]) ? !last_m : req_a[1];
         last_m    = w;
         g_cyc     = cyc + 1;
         g_port    = w;
         g_we      = cur[w].we;
         g_addr    = cur[w].addr;
         g_wdata   = cur[w].wdata;
         next_free = cyc + 4;
         if (cur[w].we) shadow[cur[w].addr] = cur[w].wdata;
         else           g_exp = shadow[cur[w].addr];
      end
   endtask

   task automatic run_engine(input int rand_cycles, input int pct, input string tag);
      int lim;
      txn_t z;
      lim = rand_cycles + 200;
      z = '{we: 1'b0, addr: '0, wdata: '0};
      cyc = 0; next_free = 0; g_cyc = -100; g_port = 1'b0; g_we = 1'b0;
      req_a[0] = 1'b0; req_a[1] = 1'b0;
      log_cyc.delete(); log_port.delete();
      forever begin
         @(negedge clk_i);
         engine_cycle((cyc < rand_cycles) ? pct : 0, tag);
         if (cyc >= rand_cycles && q_p.size() == 0 && q_d.size() == 0 &&
             !req_a[0] && !req_a[1] && cyc > g_cyc + 3) break;
         if (cyc >= lim) begin
            checks++; errors++;
            $display("FAIL %s_drain: still busy at cycle %0d, limit %0d", tag, cyc, lim);
            drive(1'b0, 1'b0, z); drive(1'b1, 1'b0, z);
            break;
         end
         cyc++;
      end
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [14];
      txn_t t;
      int   nz, bad, ndone;
      bit   last_before;

      tbl[0]  = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1'b1, 1'b1, 12'h100, 32'h55AA55AA, 32'h0};
      tbl[3]  = '{1'b1, 1'b0, 12'h100, 32'h0,        32'h55AA55AA};
      tbl[4]  = '{1'b0, 1'b0, 12'h100, 32'h0,        32'h55AA55AA};
      tbl[5]  = '{1'b1, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
      tbl[6]  = '{1'b0, 1'b1, 12'hFFF, 32'hFFFFFFFF, 32'h0};
      tbl[7]  = '{1'b0, 1'b0, 12'hFFF, 32'h0,        32'hFFFFFFFF};
      tbl[8]  = '{1'b1, 1'b1, 12'h000, 32'h00000000, 32'h0};
      tbl[9]  = '{1'b1, 1'b0, 12'h000, 32'h0,        32'h00000000};
      tbl[10] = '{1'b1, 1'b0, 12'h7FF, 32'h0,        32'hA5A507FF};
      tbl[11] = '{1'b0, 1'b1, 12'h010, 32'h0BADF00D, 32'h0};
      tbl[12] = '{1'b0, 1'b0, 12'h010, 32'h0,        32'h0BADF00D};
      tbl[13] = '{1'b0, 1'b0, 12'h0FF, 32'h0,        32'hA5A500FF};

      for (int i = 0; i < 4096; i++) shadow[i] = init_word(12'(i));
      reset_model();

      // reset, then idle
      #2 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check("reset_outs", all_outs(), '0);
      rst_ni = 1'b1;
      nz = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (all_outs() !== '0) nz++;
      end
      check("idle_nonzero_cycles", nz, 0);

      // simultaneous first request after reset: P wins, D follows 4 cycles later
      q_p.push_back('{we: 1'b0, addr: 12'h001, wdata: 32'h0});
      q_d.push_back('{we: 1'b0, addr: 12'h002, wdata: 32'h0});
      run_engine(0, 0, "tie");
      check("tie_grants", {32'(log_port.size()), 1'(log_port[0]), 32'(log_cyc[0]),
                           1'(log_port[1]), 32'(log_cyc[1])},
                          {32'd2, 1'b0, 32'd1, 1'b1, 32'd5});
      check("tie_rdata", {p_rdata_o, d_rdata_o}, {32'hA5A50001, 32'hA5A50002});

      // table of single-port accesses
      for (int i = 0; i < 14; i++) begin
         t = '{we: tbl[i].we, addr: tbl[i].addr, wdata: tbl[i].wdata};
         single_access(tbl[i].port, t, tbl[i].exp_rd, $sformatf("tbl%0d", i));
      end

      // write isolation: last = P, so D's write goes first and P reads it back
      q_p.push_back('{we: 1'b0, addr: 12'h0FF, wdata: 32'h0});
      q_d.push_back('{we: 1'b1, addr: 12'h0FF, wdata: 32'h12345678});
      run_engine(0, 0, "iso");
      check("iso_grants", {32'(log_port.size()), 1'(log_port[0]), 32'(log_cyc[0]),
                           1'(log_port[1]), 32'(log_cyc[1])},
                          {32'd2, 1'b1, 32'd1, 1'b0, 32'd5});
      check("iso_p_rdata", p_rdata_o, 32'h12345678);

      // sustained contention
      last_before = last_m;
      run_engine(36, 100, "contend");
      bad = 0;
      for (int i = 1; i < log_port.size(); i++) begin
         if (log_port[i] == log_port[i-1] || log_cyc[i] - log_cyc[i-1] != 4) bad++;
      end
      check("contend_count_ge8", 32'(log_port.size() >= 8), 32'd1);
      check("contend_alt_violations", bad, 0);
      check("contend_first_port", log_port[0], !last_before);

      // randomized two-port traffic
      run_engine(3000, 35, "rand");

      // reset during GRANT of a P write
      t = '{we: 1'b1, addr: 12'h010, wdata: 32'hCAFEF00D};
      @(negedge clk_i);
      drive(1'b0, 1'b1, t);
      @(negedge clk_i);
      check("abort_grant_cycle", {p_gnt_o, mem_wren_o, busy_o}, 3'b111);
      #2 rst_ni = 1'b0;
      #1 check("abort_outs_in_reset", all_outs(), '0);
      drive(1'b0, 1'b0, t);
      reset_model();
      ndone = 0;
      repeat (2) begin
         @(negedge clk_i);
         if (p_done_o || d_done_o) ndone++;
      end
      rst_ni = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         if (p_done_o || d_done_o || busy_o) ndone++;
      end
      check("abort_no_done", ndone, 0);
      t = '{we: 1'b0, addr: 12'h020, wdata: 32'h0};
      single_access(1'b0, t, 32'hA5A50020, "post_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
